shift_right_sipo: RTL and testbench

//   Serial-in / parallel-out shift register, right-shifting. Each clock edge

---
 rtl/shift_right_sipo_pkg.sv | 11 +
 rtl/shift_right_sipo.sv | 37 +++
 tb/tb_shift_right_sipo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shift_right_sipo_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// Sizes the saturating bit counter so that it can hold the value WIDTH itself.
package shift_right_sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 4;

  function automatic int unsigned sipo_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_right_sipo.sv
// Right-shifting SIPO: serial bit enters the MSB each clock, word flag after WIDTH bits.
// Latency 1 cycle serial-to-MSB; no backpressure, every non-reset edge shifts.
module shift_right_sipo
  import shift_right_sipo_pkg::*;
#(
  parameter int unsigned      WIDTH       = SIPO_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_data_in,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             word_ready
);

  localparam int unsigned CW = sipo_cnt_width(WIDTH);

  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      parallel_data_out <= RESET_VALUE;
      bit_cnt           <= '0;
      word_ready        <= 1'b0;
    end else begin
      parallel_data_out <= {serial_data_in, parallel_data_out[WIDTH-1:1]};
      // Counter saturates at WIDTH; the flag is sticky so it never wraps back low.
      if (bit_cnt != CW'(WIDTH)) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (bit_cnt >= CW'(WIDTH - 1)) begin
        word_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_right_sipo.sv
// Randomized self-checking bench for shift_right_sipo (WIDTH=4, two reset values).
module tb_shift_right_sipo;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         serial_data_in;
  logic [W-1:0] pdo_a;
  logic         rdy_a;
  logic [W-1:0] pdo_b;
  logic         rdy_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: word values as integers and number of bits seen since reset.
  int mw_a;
  int mw_b;
  int nbits;

  shift_right_sipo #(.WIDTH(W), .RESET_VALUE(4'b0000)) dut_a (
    .clk               (clk),
    .reset             (reset),
    .serial_data_in    (serial_data_in),
    .parallel_data_out (pdo_a),
    .word_ready        (rdy_a)
  );

  shift_right_sipo #(.WIDTH(W), .RESET_VALUE(4'b1010)) dut_b (
    .clk               (clk),
    .reset             (reset),
    .serial_data_in    (serial_data_in),
    .parallel_data_out (pdo_b),
    .word_ready        (rdy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mw_a  = 0;
    mw_b  = 'hA;
    nbits = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " pdo_a"}, {28'd0, pdo_a}, mw_a);
    chk({tag, " rdy_a"}, {31'd0, rdy_a}, (nbits >= W) ? 1 : 0);
    chk({tag, " pdo_b"}, {28'd0, pdo_b}, mw_b);
    chk({tag, " rdy_b"}, {31'd0, rdy_b}, (nbits >= W) ? 1 : 0);
  endtask

  // Drive at the falling edge, let one rising edge act, then sample 1 ns later.
  task automatic step(input string tag, input logic r, input logic s);
    @(negedge clk);
    reset          = r;
    serial_data_in = s;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      mw_a  = (mw_a >> 1) + (s ? (1 << (W - 1)) : 0);
      mw_b  = (mw_b >> 1) + (s ? (1 << (W - 1)) : 0);
      nbits = nbits + 1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] seq_bits;
    logic [3:0] seq_exp [5];
    seq_bits   = 4'b0000;
    seq_exp[0] = 4'b0000;
    seq_exp[1] = 4'b1000;
    seq_exp[2] = 4'b0100;
    seq_exp[3] = 4'b1010;
    seq_exp[4] = 4'b1101;

    // Reset over the first edge at 5 ns.
    reset          = 1'b1;
    serial_data_in = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset pdo_a", {28'd0, pdo_a}, 32'h0);
    chk("reset rdy_a", {31'd0, rdy_a}, 32'h0);
    chk("reset pdo_b", {28'd0, pdo_b}, 32'hA);
    check_all("reset");

    // Directed sequence 0,1,0,1,1.
    for (int i = 0; i < 5; i++) begin
      logic sb;
      sb = (i == 1 || i >= 3) ? 1'b1 : 1'b0;
      step("seq", 1'b0, sb);
      chk("seq const", {28'd0, pdo_a}, {28'd0, seq_exp[i]});
      if (i == 0) chk("rv shift", {28'd0, pdo_b}, 32'h5);
      chk("seq rdy const", {31'd0, rdy_a}, (i >= 3) ? 32'h1 : 32'h0);
    end

    // Full flush with ones then zeros.
    for (int i = 0; i < 4; i++) step("ones", 1'b0, 1'b1);
    chk("flush ones", {28'd0, pdo_a}, 32'hF);
    for (int i = 0; i < 4; i++) begin
      step("zeros", 1'b0, 1'b0);
      seq_bits = 4'b1111 >> (i + 1);
      chk("zeros step", {28'd0, pdo_a}, {28'd0, seq_bits});
    end

    // Mid-stream reset after two bits.
    step("mid", 1'b0, 1'b1);
    step("mid", 1'b0, 1'b1);
    chk("mid partial", {28'd0, pdo_a}, 32'hC);
    step("mid rst", 1'b1, 1'b1);
    chk("mid rst pdo", {28'd0, pdo_a}, 32'h0);
    chk("mid rst rdy", {31'd0, rdy_a}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step("refill", 1'b0, 1'($urandom_range(0, 1)));
      chk("refill rdy", {31'd0, rdy_a}, (i == 3) ? 32'h1 : 32'h0);
    end

    // Random stream with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
